axis_append_a2: RTL and testbench
=================================

// Module: axis_append_a2
// PURPOSE
//  Wraps every AXI-Stream packet with a programmable number of header beats before it and trailer beats after it.
//  Generalises the single head/end append: parametrised data width, 0..MAX_HEAD header and 0..MAX_END trailer beats.
//  Counts are chosen per packet, and the block can be bypassed per packet.
//  Sits between packet sources and framers/DMA writers in the stream datapath.
// PARAMETERS
//  DSIZE     32  tdata width in bits
//  MAX_HEAD  4   max header beats per packet (>=1)
//  MAX_END   4   max trailer beats per packet (>=1)
// PORTS
//  clock            in   1                        single clock for all logic
//  rst              in   1                        synchronous reset, active-high
//  enable           in   1                        1=wrap packet, 0=pass unchanged; sampled at packet start
//  head_num         in   $clog2(MAX_HEAD+1)       header beat count, sampled at packet start
//  end_num          in   $clog2(MAX_END+1)        trailer beat count, sampled at packet start
//  head_value       in   DSIZE                    header beat data, sampled at packet start
//  end_value        in   DSIZE                    trailer beat data, sampled at packet start
//  origin_tdata     in   DSIZE                    input stream data
//  origin_tvalid    in   1                        input stream valid
//  origin_tlast     in   1                        input stream last
//  origin_tready    out  1                        input stream ready
//  append_tdata     out  DSIZE                    output stream data
//  append_tvalid    out  1                        output stream valid
//  append_tlast     out  1                        output stream last
//  append_tready    in   1                        output stream ready
//  pkt_cnt          out  32                       wrapped-packet count; present only with AXIS_APPEND_A2_STAT_EN
// BEHAVIOUR
//  - Reset: state=IDLE; beat counter=0; latched cfg=0; origin_tready=0; append_tvalid=0; append_tlast=0; pkt_cnt=0.
//  - Transfer rule: a beat moves on a port when tvalid&tready are both high on a rising clock edge.
//  - Reset mid-packet: return to IDLE next cycle. The partial packet is abandoned with no trailing tlast. Downstream tolerates this.
//  - FSM state IDLE:
//      . origin_tready=0; append_tvalid=0.
//      . On origin_tvalid, latch enable, head_num, end_num, head_value and end_value.
//      . Next state is BODY if enable=0 or head_num=0, otherwise HEAD.
//  - FSM state HEAD:
//      . append_tvalid=1, tdata=head_value_l, tlast=0; origin_tready=0.
//      . Counter increments per accepted beat.
//      . After head_num_l accepted beats: counter cleared, go to BODY.
//  - FSM state BODY (zero latency, combinational pass-through):
//      . append_tdata/tvalid follow origin; origin_tready=append_tready.
//      . append_tlast = origin_tlast & (!enable_l | end_num_l==0).
//      . On the accepted origin_tlast beat: go to TAIL if enable_l & end_num_l!=0, otherwise IDLE.
//  - FSM state TAIL:
//      . append_tvalid=1, tdata=end_value_l; origin_tready=0.
//      . tlast=1 only on beat end_num_l; counter counts accepted beats.
//      . After the last accepted beat: counter cleared, go to IDLE.
//  - Config changes are ignored while a packet is in flight; only latched values are used.
//  - head_num>MAX_HEAD or end_num>MAX_END: clamped to MAX.
//  - Single-beat packet (origin_tlast on its first beat) is legal and is wrapped normally.
//  - append_tready held low stalls HEAD/TAIL with tdata/tlast stable; append_tvalid never drops until the beat is accepted.
//  - Throughput: one IDLE bubble cycle between packets. Output beats per wrapped packet = head_num + body + end_num.
// CONFIGURATION
//  AXIS_APPEND_A2_STAT_EN defined:
//    pkt_cnt port exists.
//    Increments by 1 on each completed wrapped packet, i.e. a packet with enable_l=1 whose final tlast beat is accepted.
//    Wraps 2^32-1 -> 0. Cleared by rst.
//  Not defined: pkt_cnt port and counter logic absent. All other behaviour is identical.
// STRUCTURE
//  - Package axis_append_pkg holds:
//      . typedef enum logic[1:0] {IDLE,HEAD,BODY,TAIL} append_state_e
//      . function cnt_w(int max) returning $clog2(max+1)
//  - No sub-module: FSM, beat counter and config latch live in this module.
// TESTING
//  1 DSIZE=32, head_num=2, end_num=1, head_value=AA, end_value=EE, 3-beat packet 1,2,3 -> out AA,AA,1,2,3,EE; tlast only on EE.
//  2 enable=0, 4-beat packet -> output identical to input, tlast on beat 4, pkt_cnt unchanged (STAT_EN).
//  3 head_num=0, end_num=0, enable=1, 1-beat packet 5 -> out 5 with tlast; pkt_cnt +1.
//  4 head_num=3, end_num=2, random append_tready 50% -> data/tlast stable while stalled; 10 packets; pkt_cnt=10.
//  5 change head_value/end_num mid-BODY -> current packet uses latched values; next packet uses new ones.
//  6 assert rst during TAIL beat 1 of 2 -> next cycle append_tvalid=0, state IDLE; next packet wraps correctly.

Source files
------------

// File: rtl/axis_append_pkg.sv
// axis_append_pkg: shared FSM state type and counter-width helper for axis_append_a2
package axis_append_pkg;
  typedef enum logic [1:0] {IDLE, HEAD, BODY, TAIL} append_state_e;
  function automatic int cnt_w(int max);
    return $clog2(max + 1);
  endfunction
endpackage

// File: rtl/axis_append_a2.sv
// axis_append_a2: wraps each AXI-Stream packet with head_num header beats and end_num trailer beats.
// Ports: clock/rst (sync, active-high); enable, head_num, end_num, head_value, end_value are
// sampled at packet start; origin_* is the input stream, append_* the output stream.
// Optional macro AXIS_APPEND_A2_STAT_EN adds pkt_cnt, the count of completed wrapped packets.
module axis_append_a2
  import axis_append_pkg::*;
#(
  parameter int DSIZE    = 32,
  parameter int MAX_HEAD = 4,
  parameter int MAX_END  = 4
) (
  input  logic                          clock,
  input  logic                          rst,
  input  logic                          enable,
  input  logic [cnt_w(MAX_HEAD)-1:0]    head_num,
  input  logic [cnt_w(MAX_END)-1:0]     end_num,
  input  logic [DSIZE-1:0]              head_value,
  input  logic [DSIZE-1:0]              end_value,
  input  logic [DSIZE-1:0]              origin_tdata,
  input  logic                          origin_tvalid,
  input  logic                          origin_tlast,
  output logic                          origin_tready,
  output logic [DSIZE-1:0]              append_tdata,
  output logic                          append_tvalid,
  output logic                          append_tlast,
  input  logic                          append_tready
`ifdef AXIS_APPEND_A2_STAT_EN
  ,
  output logic [31:0]                   pkt_cnt
`endif
);
  localparam int HW = cnt_w(MAX_HEAD);
  localparam int EW = cnt_w(MAX_END);
  localparam int CW = HW > EW ? HW : EW;
  append_state_e state, state_nx;
  logic [CW-1:0] cnt, cnt_nx, cnt_inc;
  logic enable_l;
  logic [HW-1:0] head_num_l;
  logic [EW-1:0] end_num_l;
  logic [DSIZE-1:0] head_value_l, end_value_l;
  logic head_done, tail_done;
  assign cnt_inc   = cnt + CW'(1);
  assign head_done = cnt_inc == CW'(head_num_l);
  assign tail_done = cnt_inc == CW'(end_num_l);
  always_comb begin
    state_nx      = state;
    cnt_nx        = cnt;
    origin_tready = 1'b0;
    append_tvalid = 1'b0;
    append_tdata  = head_value_l;
    append_tlast  = 1'b0;
    unique case (state)
      IDLE: if (origin_tvalid) state_nx = (!enable || head_num == '0) ? BODY : HEAD;
      HEAD: begin
        append_tvalid = 1'b1;
        if (append_tready) begin
          cnt_nx   = head_done ? '0 : cnt_inc;
          state_nx = head_done ? BODY : HEAD;
        end
      end
      BODY: begin
        append_tdata  = origin_tdata;
        append_tvalid = origin_tvalid;
        origin_tready = append_tready;
        append_tlast  = origin_tlast & (!enable_l | end_num_l == '0);
        if (origin_tvalid && append_tready && origin_tlast)
          state_nx = (enable_l && end_num_l != '0) ? TAIL : IDLE;
      end
      TAIL: begin
        append_tvalid = 1'b1;
        append_tdata  = end_value_l;
        append_tlast  = tail_done;
        if (append_tready) begin
          cnt_nx   = tail_done ? '0 : cnt_inc;
          state_nx = tail_done ? IDLE : TAIL;
        end
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      enable_l     <= 1'b0;
      head_num_l   <= '0;
      end_num_l    <= '0;
      head_value_l <= '0;
      end_value_l  <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      // out-of-range counts are clamped once, at latch time
      if (state == IDLE && origin_tvalid) begin
        enable_l     <= enable;
        head_num_l   <= head_num > HW'(MAX_HEAD) ? HW'(MAX_HEAD) : head_num;
        end_num_l    <= end_num > EW'(MAX_END) ? EW'(MAX_END) : end_num;
        head_value_l <= head_value;
        end_value_l  <= end_value;
      end
    end
  end
`ifdef AXIS_APPEND_A2_STAT_EN
  // the accepted tlast beat of a wrapped packet is always its final beat
  always_ff @(posedge clock) begin
    if (rst) pkt_cnt <= '0;
    else if (append_tvalid && append_tready && append_tlast && enable_l) pkt_cnt <= pkt_cnt + 32'd1;
  end
`endif
endmodule

// File: tb/tb_axis_append_a2.sv
// tb_axis_append_a2: scoreboard bench for axis_append_a2 using directed packets
module tb_axis_append_a2;
  logic clock = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  logic [2:0] head_num = '0, end_num = '0;
  logic [31:0] head_value = '0, end_value = '0, origin_tdata = '0;
  logic origin_tvalid = 1'b0, origin_tlast = 1'b0, append_tready = 1'b0;
  logic origin_tready, append_tvalid, append_tlast;
  logic [31:0] append_tdata;
`ifdef AXIS_APPEND_A2_STAT_EN
  logic [31:0] pkt_cnt;
`endif
  axis_append_a2 dut (
    .clock(clock), .rst(rst), .enable(enable), .head_num(head_num), .end_num(end_num),
    .head_value(head_value), .end_value(end_value),
    .origin_tdata(origin_tdata), .origin_tvalid(origin_tvalid), .origin_tlast(origin_tlast),
    .origin_tready(origin_tready), .append_tdata(append_tdata), .append_tvalid(append_tvalid),
    .append_tlast(append_tlast), .append_tready(append_tready)
`ifdef AXIS_APPEND_A2_STAT_EN
    , .pkt_cnt(pkt_cnt)
`endif
  );
  always #5 clock = ~clock;
  logic [32:0] exp_q[$];
  int nvec = 0, nerr = 0, rmode = 0, exp_pkt = 0;
  logic stalled = 1'b0;
  logic [32:0] held = '0;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    nvec++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask
  task automatic cfg(input logic en, input int hn, input int tn, input logic [31:0] hv, input logic [31:0] ev);
    enable = en; head_num = 3'(hn); end_num = 3'(tn); head_value = hv; end_value = ev;
  endtask
  task automatic push_pkt(input logic en, input int hn, input int tn, input logic [31:0] hv,
                          input logic [31:0] ev, input int n, input logic [31:0] base);
    int h, t;
    h = en ? (hn > 4 ? 4 : hn) : 0;
    t = en ? (tn > 4 ? 4 : tn) : 0;
    for (int i = 0; i < h; i++) exp_q.push_back({hv, 1'b0});
    for (int i = 0; i < n; i++) exp_q.push_back({base + 32'(i), i == n - 1 && t == 0});
    for (int i = 0; i < t; i++) exp_q.push_back({ev, i == t - 1});
    if (en) exp_pkt++;
  endtask
  task automatic send(input int n, input logic [31:0] base, input logic chg);
    int t;
    origin_tvalid = 1'b1;
    for (int i = 0; i < n; i++) begin
      origin_tdata = base + 32'(i);
      origin_tlast = i == n - 1;
      t = 0;
      do begin
        @(negedge clock);
        t++;
      end while (!origin_tready && t < 1000);
      if (!origin_tready) begin
        nvec++; nerr++;
        $display("FAIL send_timeout: got no origin_tready expected ready within 1000 cycles");
      end
      @(posedge clock); #1;
      if (chg && i == 0) begin
        head_value = 32'hA2;
        end_num = 3'd2;
      end
    end
    origin_tvalid = 1'b0;
    origin_tlast = 1'b0;
  endtask
  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 2000) begin
      @(posedge clock);
      t++;
    end
    repeat (2) @(posedge clock);
    #1;
    check("drain_left", 64'(exp_q.size()), 64'd0);
  endtask
  task automatic check_pkt();
`ifdef AXIS_APPEND_A2_STAT_EN
    check("pkt_cnt", 64'(pkt_cnt), 64'(exp_pkt));
`endif
  endtask
  initial forever begin
    @(posedge clock); #1;
    if (rmode == 0) append_tready = 1'b1;
    else if (rmode == 1) append_tready = 1'($urandom_range(0, 1));
  end
  initial forever begin
    @(negedge clock);
    if (rst) stalled = 1'b0;
    else begin
      if (stalled) check("stall_hold", 64'({append_tvalid, append_tdata, append_tlast}), 64'({1'b1, held}));
      if (append_tvalid && append_tready) begin
        if (exp_q.size() == 0) begin
          nvec++; nerr++;
          $display("FAIL extra_beat: got %0h/%0b expected no beat", append_tdata, append_tlast);
        end else check("beat", 64'({append_tdata, append_tlast}), 64'(exp_q.pop_front()));
      end
      stalled = append_tvalid && !append_tready;
      held = {append_tdata, append_tlast};
    end
  end
  initial begin
    repeat (3) @(posedge clock);
    #1;
    check("rst_valid", 64'(append_tvalid), 64'd0);
    check("rst_ready", 64'(origin_tready), 64'd0);
    check("rst_tlast", 64'(append_tlast), 64'd0);
    check_pkt();
    rst = 1'b0;
    cfg(1, 2, 1, 32'hAA, 32'hEE);
    push_pkt(1, 2, 1, 32'hAA, 32'hEE, 3, 32'd1);
    send(3, 32'd1, 0);
    drain();
    cfg(0, 3, 2, 32'hAA, 32'hEE);
    push_pkt(0, 3, 2, 32'hAA, 32'hEE, 4, 32'h10);
    send(4, 32'h10, 0);
    drain();
    check_pkt();
    cfg(1, 0, 0, 32'hAA, 32'hEE);
    push_pkt(1, 0, 0, 32'hAA, 32'hEE, 1, 32'd5);
    send(1, 32'd5, 0);
    drain();
    check_pkt();
    cfg(1, 7, 6, 32'h11, 32'h22);
    push_pkt(1, 7, 6, 32'h11, 32'h22, 2, 32'h30);
    send(2, 32'h30, 0);
    drain();
    rmode = 1;
    cfg(1, 3, 2, 32'hC0DE, 32'hBEEF);
    for (int p = 0; p < 10; p++) begin
      push_pkt(1, 3, 2, 32'hC0DE, 32'hBEEF, 1 + p % 4, 32'(p * 16 + 256));
      send(1 + p % 4, 32'(p * 16 + 256), 0);
    end
    drain();
    rmode = 0;
    check_pkt();
    cfg(1, 1, 1, 32'hA1, 32'hE1);
    push_pkt(1, 1, 1, 32'hA1, 32'hE1, 3, 32'h40);
    send(3, 32'h40, 1);
    push_pkt(1, 1, 2, 32'hA2, 32'hE1, 2, 32'h50);
    send(2, 32'h50, 0);
    drain();
    check_pkt();
    rmode = 2;
    append_tready = 1'b1;
    cfg(1, 0, 2, 32'hAA, 32'h77);
    exp_q.push_back({32'h60, 1'b0});
    send(1, 32'h60, 0);
    append_tready = 1'b0;
    @(negedge clock);
    check("tail_beat1", 64'({append_tvalid, append_tdata, append_tlast}), 64'({1'b1, 32'h77, 1'b0}));
    @(posedge clock); #1;
    rst = 1'b1;
    @(posedge clock); #1;
    check("rst_mid_valid", 64'(append_tvalid), 64'd0);
    check("rst_mid_ready", 64'(origin_tready), 64'd0);
    exp_pkt = 0;
    check_pkt();
    rst = 1'b0;
    rmode = 0;
    cfg(1, 1, 1, 32'h99, 32'h88);
    push_pkt(1, 1, 1, 32'h99, 32'h88, 2, 32'h70);
    send(2, 32'h70, 0);
    drain();
    check_pkt();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
